// File: rtl/fpu_cmd_seq.sv
// Command sequencer in front of a single-precision FPU core: queues requests,
// issues them one at a time, watches for completion or hang, returns tagged results.
module fpu_cmd_seq #(
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned TAG_W   = 4,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [31:0]      cmd_a,
  input  logic [31:0]      cmd_b,
  input  logic [1:0]       cmd_op,
  input  logic [TAG_W-1:0] cmd_tag,
  output logic [31:0]      fpu_a,
  output logic [31:0]      fpu_b,
  output logic [1:0]       fpu_op,
  output logic             fpu_go,
  output logic             fpu_abort,
  input  logic [31:0]      fpu_d,
  input  logic             fpu_done,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [31:0]      rsp_d,
  output logic [TAG_W-1:0] rsp_tag,
  output logic             rsp_nan,
  output logic             rsp_inf,
  output logic             rsp_zero,
  output logic             rsp_timeout,
  output logic             busy
);

  localparam int unsigned PW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW  = PW + 1;
  localparam int unsigned WDW = $clog2(TIMEOUT);

  typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_ARM, S_WAIT, S_ABORT} state_t;

  state_t state, state_next;

  logic [31:0]      q_a   [DEPTH];
  logic [31:0]      q_b   [DEPTH];
  logic [1:0]       q_op  [DEPTH];
  logic [TAG_W-1:0] q_tag [DEPTH];

  logic [PW-1:0]    wr_ptr, rd_ptr;
  logic [CW-1:0]    count;
  logic [WDW-1:0]   wd;
  logic [TAG_W-1:0] tag_q;
  logic             push, pop;

  assign cmd_ready = reset_n && (count < CW'(DEPTH));
  assign push      = cmd_valid && cmd_ready;
  assign fpu_go    = (state == S_ISSUE);
  // The FPU is held in reset whenever this block is, not only on a watchdog abort.
  assign fpu_abort = (state == S_ABORT) || !reset_n;
  assign busy      = (state != S_IDLE);

  always_comb begin
    state_next = state;
    pop        = 1'b0;
    case (state)
      S_IDLE: begin
        if ((count != '0) && (!rsp_valid || rsp_ready)) begin
          pop        = 1'b1;
          state_next = S_ISSUE;
        end
      end
      S_ISSUE: state_next = S_ARM;
      S_ARM:   state_next = S_WAIT;
      S_WAIT: begin
        if (fpu_done)                        state_next = S_IDLE;
        else if (wd == WDW'(TIMEOUT - 1))    state_next = S_ABORT;
      end
      S_ABORT: state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) begin
      q_a[wr_ptr]   <= cmd_a;
      q_b[wr_ptr]   <= cmd_b;
      q_op[wr_ptr]  <= cmd_op;
      q_tag[wr_ptr] <= cmd_tag;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= S_IDLE;
      wd          <= '0;
      fpu_a       <= '0;
      fpu_b       <= '0;
      fpu_op      <= '0;
      tag_q       <= '0;
      rsp_valid   <= 1'b0;
      rsp_d       <= '0;
      rsp_tag     <= '0;
      rsp_nan     <= 1'b0;
      rsp_inf     <= 1'b0;
      rsp_zero    <= 1'b0;
      rsp_timeout <= 1'b0;
    end else begin
      state <= state_next;
      if (pop) begin
        fpu_a  <= q_a[rd_ptr];
        fpu_b  <= q_b[rd_ptr];
        fpu_op <= q_op[rd_ptr];
        tag_q  <= q_tag[rd_ptr];
      end
      if (state == S_ARM)       wd <= '0;
      else if (state == S_WAIT) wd <= wd + WDW'(1);

      if (rsp_valid && rsp_ready) rsp_valid <= 1'b0;
      if (state == S_WAIT && fpu_done) begin
        rsp_valid   <= 1'b1;
        rsp_d       <= fpu_d;
        rsp_tag     <= tag_q;
        rsp_nan     <= (&fpu_d[30:23]) && (|fpu_d[22:0]);
        rsp_inf     <= (&fpu_d[30:23]) && !(|fpu_d[22:0]);
        rsp_zero    <= !(|fpu_d[30:23]);
        rsp_timeout <= 1'b0;
      end else if (state == S_ABORT) begin
        rsp_valid   <= 1'b1;
        rsp_d       <= 32'h7FFF_FFFF;
        rsp_tag     <= tag_q;
        rsp_nan     <= 1'b1;
        rsp_inf     <= 1'b0;
        rsp_zero    <= 1'b0;
        rsp_timeout <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_fpu_cmd_seq.sv
// Self-checking bench for fpu_cmd_seq: FPU stub, scoreboard queue and directed
// plus randomized command sequences.
`timescale 1ns/1ps
module tb_fpu_cmd_seq;

  localparam int unsigned DEPTH   = 4;
  localparam int unsigned TW      = 4;
  localparam int unsigned TIMEOUT = 16;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [31:0]   cmd_a, cmd_b;
  logic [1:0]    cmd_op;
  logic [TW-1:0] cmd_tag;
  logic [31:0]   fpu_a, fpu_b;
  logic [1:0]    fpu_op;
  logic          fpu_go, fpu_abort;
  logic [31:0]   fpu_d;
  logic          fpu_done;
  logic          rsp_valid, rsp_ready;
  logic [31:0]   rsp_d;
  logic [TW-1:0] rsp_tag;
  logic          rsp_nan, rsp_inf, rsp_zero, rsp_timeout;
  logic          busy;

  fpu_cmd_seq #(.DEPTH(DEPTH), .TAG_W(TW), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset_n(reset_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_op(cmd_op), .cmd_tag(cmd_tag),
    .fpu_a(fpu_a), .fpu_b(fpu_b), .fpu_op(fpu_op),
    .fpu_go(fpu_go), .fpu_abort(fpu_abort),
    .fpu_d(fpu_d), .fpu_done(fpu_done),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_d(rsp_d), .rsp_tag(rsp_tag),
    .rsp_nan(rsp_nan), .rsp_inf(rsp_inf), .rsp_zero(rsp_zero),
    .rsp_timeout(rsp_timeout), .busy(busy)
  );

  always #5 clk = ~clk;

  // FPU behaviour: a few IEEE results for the directed cases, a scrambling
  // function otherwise; 1.0-1.0 subtraction models a non-terminating core.
  function automatic logic [31:0] fpu_fn(input logic [31:0] a, input logic [31:0] b,
                                         input logic [1:0] op);
    if (op == 2'd0 && a == 32'h4000_0000 && b == 32'h4040_0000) return 32'h40C0_0000;
    if (op == 2'd2 && a == 32'h3F80_0000 && b == 32'h3F80_0000) return 32'h4000_0000;
    if (op == 2'd1 && a == 32'h3F80_0000 && b == 32'h0000_0000) return 32'h7F80_0000;
    if (op == 2'd0 && a == 32'h0000_0000)                        return 32'h0000_0000;
    return (a ^ {b[15:0], b[31:16]}) + {30'd0, op};
  endfunction

  function automatic bit fpu_hangs(input logic [31:0] a, input logic [31:0] b,
                                   input logic [1:0] op);
    return op == 2'd3 && a == 32'h3F80_0000 && b == 32'h3F80_0000;
  endfunction

  // Stub core: captures go one cycle late and only then clears a stale done.
  int          stub_lat = 0;
  logic        go_d, run;
  int          cnt;
  logic [31:0] la, lb;
  logic [1:0]  lop;
  always @(posedge clk or posedge fpu_abort) begin
    if (fpu_abort) begin
      go_d <= 1'b0; run <= 1'b0; cnt <= 0; fpu_done <= 1'b0; fpu_d <= '0;
    end else begin
      go_d <= fpu_go;
      if (go_d) begin
        fpu_done <= 1'b0;
        la <= fpu_a; lb <= fpu_b; lop <= fpu_op;
        run <= !fpu_hangs(fpu_a, fpu_b, fpu_op);
        cnt <= stub_lat;
      end else if (run) begin
        if (cnt == 0) begin
          fpu_done <= 1'b1;
          fpu_d    <= fpu_fn(la, lb, lop);
          run      <= 1'b0;
        end else cnt <= cnt - 1;
      end
    end
  end

  int          go_cnt = 0, abort_cnt = 0, hold_err = 0;
  logic [31:0] ga, gb;
  logic [1:0]  gop;
  always @(posedge clk) begin
    if (fpu_go) go_cnt++;
    if (fpu_abort) abort_cnt++;
    if (fpu_go) begin
      ga <= fpu_a; gb <= fpu_b; gop <= fpu_op;
    end else if (busy && (fpu_a !== ga || fpu_b !== gb || fpu_op !== gop)) hold_err++;
  end

  typedef struct {
    logic [TW-1:0] tag;
    logic [31:0]   d;
    logic          to;
  } exp_t;
  exp_t exp_q[$];

  int  n_assert = 0, n_fail = 0;
  time t_push;

  task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", name, obs, exp);
    end
  endtask

  task automatic clear_mon();
    go_cnt = 0; abort_cnt = 0; hold_err = 0;
  endtask

  task automatic push_cmd(input logic [31:0] a, input logic [31:0] b,
                          input logic [1:0] op, input logic [TW-1:0] tag);
    exp_t e;
    int   i;
    cmd_valid = 1'b1; cmd_a = a; cmd_b = b; cmd_op = op; cmd_tag = tag;
    for (i = 0; i < 300 && cmd_ready !== 1'b1; i++) @(negedge clk);
    check("cmd_accept", cmd_ready, 1'b1);
    t_push = $time;
    e.tag = tag;
    e.to  = fpu_hangs(a, b, op);
    e.d   = e.to ? 32'h7FFF_FFFF : fpu_fn(a, b, op);
    if (cmd_ready === 1'b1) exp_q.push_back(e);
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  // Waits for a response, optionally holds ready low for a while, compares
  // every field against the oldest outstanding command, then accepts it.
  task automatic check_rsp(input int exp_lat, input int hold_cycles);
    exp_t e;
    int   i;
    time  t_obs;
    for (i = 0; i < 300 && rsp_valid !== 1'b1; i++) @(negedge clk);
    check("rsp_valid", rsp_valid, 1'b1);
    t_obs = $time;
    if (exp_lat >= 0) check("latency", 32'(int'((t_obs - t_push) / 10) - 1), 32'(exp_lat));
    repeat (hold_cycles) @(negedge clk);
    check("scoreboard_nonempty", 32'(exp_q.size() > 0), 32'd1);
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("rsp_tag", 32'(rsp_tag), 32'(e.tag));
      check("rsp_d", rsp_d, e.d);
      check("rsp_timeout", rsp_timeout, e.to);
      check("rsp_nan", rsp_nan, (e.d[30:23] == 8'hFF) && (e.d[22:0] != 0));
      check("rsp_inf", rsp_inf, (e.d[30:23] == 8'hFF) && (e.d[22:0] == 0));
      check("rsp_zero", rsp_zero, e.d[30:23] == 8'h00);
      check("go_pulses", 32'(go_cnt), 32'd1);
      check("abort_pulses", 32'(abort_cnt), e.to ? 32'd1 : 32'd0);
      check("operand_hold", 32'(hold_err), 32'd0);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    clear_mon();
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    logic [31:0] ra, rb;
    logic [1:0]  rop;
    int          lat;

    reset_n = 1'b0; cmd_valid = 1'b0; rsp_ready = 1'b0;
    cmd_a = '0; cmd_b = '0; cmd_op = '0; cmd_tag = '0;
    repeat (3) @(negedge clk);
    check("rst_abort", fpu_abort, 1'b1);
    check("rst_cmd_ready", cmd_ready, 1'b0);
    check("rst_rsp_valid", rsp_valid, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_go", fpu_go, 1'b0);
    check("rst_fpu_a", fpu_a, 32'd0);
    check("rst_rsp_d", rsp_d, 32'd0);
    check("rst_rsp_zero", rsp_zero, 1'b0);
    reset_n = 1'b1;
    @(negedge clk);
    check("post_rst_ready", cmd_ready, 1'b1);
    check("post_rst_abort", fpu_abort, 1'b0);
    clear_mon();

    // 1: mul 2*3, known stub latency; done seen in WAIT after 5+lat edges
    stub_lat = 2;
    push_cmd(32'h4000_0000, 32'h4040_0000, 2'd0, 4'd3);
    check_rsp(5 + 2, 0);

    // 2: add 1+1 while the previous done is still high
    stub_lat = 0;
    push_cmd(32'h3F80_0000, 32'h3F80_0000, 2'd2, 4'd7);
    check_rsp(5, 0);

    // 3: back-pressure, FIFO fill, in-order drain
    stub_lat = 1;
    for (int t = 0; t < 5; t++)
      push_cmd($urandom, $urandom, 2'($urandom_range(0, 2)), 4'(t));
    repeat (12) @(negedge clk);
    check("full_cmd_ready", cmd_ready, 1'b0);
    check("full_busy", busy, 1'b0);
    check("held_rsp_valid", rsp_valid, 1'b1);
    check("held_rsp_tag", 32'(rsp_tag), 32'(exp_q[0].tag));
    check("held_rsp_d", rsp_d, exp_q[0].d);
    fork
      push_cmd($urandom, $urandom, 2'd1, 4'd5);
      for (int t = 0; t < 6; t++) check_rsp(-1, int'($urandom_range(0, 2)));
    join

    // 4: hung FPU -> watchdog abort, then normal operation resumes
    push_cmd(32'h3F80_0000, 32'h3F80_0000, 2'd3, 4'd9);
    check_rsp(-1, 0);
    stub_lat = 3;
    push_cmd(32'h4000_0000, 32'h4040_0000, 2'd0, 4'd10);
    check_rsp(5 + 3, 0);

    // 5: classification of inf and zero
    push_cmd(32'h3F80_0000, 32'h0000_0000, 2'd1, 4'd11);
    check_rsp(-1, 1);
    push_cmd(32'h0000_0000, 32'h4000_0000, 2'd0, 4'd12);
    check_rsp(-1, 0);

    // 6: reset while waiting with two commands queued
    push_cmd(32'h3F80_0000, 32'h3F80_0000, 2'd3, 4'd1);
    push_cmd($urandom, $urandom, 2'd0, 4'd2);
    push_cmd($urandom, $urandom, 2'd2, 4'd3);
    repeat (3) @(negedge clk);
    check("pre_rst_busy", busy, 1'b1);
    reset_n = 1'b0;
    #1;
    check("mid_rst_abort", fpu_abort, 1'b1);
    check("mid_rst_rsp_valid", rsp_valid, 1'b0);
    check("mid_rst_busy", busy, 1'b0);
    @(negedge clk);
    reset_n = 1'b1;
    exp_q.delete();
    @(negedge clk);
    check("after_rst_ready", cmd_ready, 1'b1);
    repeat (4) @(negedge clk);
    check("after_rst_fifo_empty", busy, 1'b0);
    check("after_rst_no_rsp", rsp_valid, 1'b0);
    clear_mon();
    stub_lat = 1;
    push_cmd(32'h4000_0000, 32'h4040_0000, 2'd0, 4'd6);
    check_rsp(5 + 1, 0);

    // random commands against the scoreboard
    for (int n = 0; n < 24; n++) begin
      ra  = $urandom; rb = $urandom; rop = 2'($urandom_range(0, 3));
      if (fpu_hangs(ra, rb, rop)) ra ^= 32'h1;
      lat = int'($urandom_range(0, 4));
      stub_lat = lat;
      push_cmd(ra, rb, rop, 4'($urandom));
      check_rsp(5 + lat, int'($urandom_range(0, 2)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/fpu_cmd_seq.md
Name: fpu_cmd_seq

Overview:
- Command sequencer placed directly upstream of the single-precision FPU core, which exposes a, b, op, go, done, d and an active-high reset.
- Buffers IEEE-754 operation requests in a small FIFO and issues them to the FPU one at a time.
- Holds the operands and op stable for the whole operation, watches for completion, and returns tagged, classified results over a valid/ready response port.
- A watchdog aborts the FPU if it never signals done, for example when a normalisation loop fails to terminate.

Parameters:
DEPTH, 4, command FIFO entries (power of 2, >=2)
TAG_W, 4, width of the user tag carried with each command
TIMEOUT, 64, max cycles in WAIT before abort (>=8)

Ports:
clk  in  1  system clock, rising edge
reset_n  in  1  asynchronous active-low reset
cmd_valid  in  1  command present
cmd_ready  out  1  FIFO can accept; high when count<DEPTH and reset_n=1
cmd_a  in  32  operand A
cmd_b  in  32  operand B
cmd_op  in  2  0=mul 1=div 2=add 3=sub
cmd_tag  in  TAG_W  user tag
fpu_a  out  32  to FPU a
fpu_b  out  32  to FPU b
fpu_op  out  2  to FPU op
fpu_go  out  1  one-cycle start pulse
fpu_abort  out  1  drives FPU reset (active high)
fpu_d  in  32  FPU result
fpu_done  in  1  FPU done flag
rsp_valid  out  1  response held
rsp_ready  in  1  consumer accepts
rsp_d  out  32  result word
rsp_tag  out  TAG_W  tag of the command
rsp_nan  out  1  rsp_d exp=FF, frac!=0
rsp_inf  out  1  rsp_d exp=FF, frac=0
rsp_zero  out  1  rsp_d exp=00
rsp_timeout  out  1  watchdog fired
busy  out  1  state!=IDLE

Behaviour:

Reset (reset_n low, asynchronous):
- FIFO emptied.
- state=IDLE.
- All outputs 0 (fpu_a, fpu_b, fpu_op, fpu_go, rsp_*, busy), except fpu_abort.
- fpu_abort = registered abort OR !reset_n, so the FPU is reset together with this block. A reset mid-operation discards the in-flight command and the held response.

FIFO:
- Push on cmd_valid&&cmd_ready, storing {a,b,op,tag}. No bypass path.
- Pop only from IDLE.
- Pointers wrap modulo DEPTH; the count distinguishes full from empty.
- Simultaneous push and pop keeps the count unchanged.

FSM states: IDLE, ISSUE, ARM, WAIT, ABORT.
- IDLE: pop when FIFO is non-empty and the response slot is free (rsp_valid==0, or rsp_valid&&rsp_ready in the same cycle). The head loads working regs {fpu_a, fpu_b, fpu_op, tag}; next state ISSUE.
- ISSUE: fpu_go=1 for exactly this cycle -> ARM.
- ARM: fpu_go=0; fpu_done is ignored because the FPU clears done on capturing go; watchdog cleared -> WAIT.
- WAIT: watchdog increments.
  - If fpu_done=1: capture fpu_d into rsp_d, set tag and flags, rsp_valid<=1, rsp_timeout<=0 -> IDLE.
  - Else if watchdog==TIMEOUT-1: -> ABORT.
- ABORT: fpu_abort=1 for one cycle; rsp_d<=32'h7FFFFFFF, rsp_timeout<=1, rsp_valid<=1, tag kept; flags computed from rsp_d (nan=1) -> IDLE.

Operand hold:
- fpu_a, fpu_b and fpu_op change only on a pop.
- They stay stable from ISSUE until leaving WAIT or ABORT, because the FPU samples op after go.

Response slot:
- rsp_valid clears on rsp_valid&&rsp_ready.
- All rsp_* fields hold while rsp_valid&&!rsp_ready.
- Responses are returned strictly in command order.

Latency:
- Command accepted at edge T with the block idle: pop at edge T+1, fpu_go high during cycle T+1..T+2.
- rsp_valid rises on the edge after the first WAIT cycle that sees fpu_done=1.
- Total latency = FPU latency + 4 cycles.

fpu_done before ARM is never treated as completion, including a done left high from the previous operation.

Test Plan:
1. mul a=0x40000000 b=0x40400000 tag=3 -> rsp_d=0x40C00000, rsp_tag=3, all flags 0. fpu_go high for exactly 1 cycle; fpu_a/fpu_b/fpu_op stable until rsp_valid.
2. add 0x3F800000+0x3F800000 -> rsp_d=0x40000000. Check that the stale done=1 left by the prior command is not taken as completion.
3. Hold rsp_ready=0 and push 6 commands with tags 0..5 -> cmd_ready deasserts once the FIFO holds DEPTH entries. Release rsp_ready -> responses arrive with tags 0..5 in order, none lost or duplicated.
4. sub a=b=0x3F800000 (FPU never asserts done) -> after TIMEOUT cycles fpu_abort pulses for 1 cycle; rsp_d=0x7FFFFFFF, rsp_timeout=1, rsp_nan=1. A following mul 2.0*3.0 returns 0x40C00000 normally.
5. div 0x3F800000/0x00000000 -> rsp_d=0x7F800000, rsp_inf=1; mul 0*0x40000000 -> rsp_zero=1.
6. Assert reset_n=0 during WAIT with 2 commands queued -> fpu_abort=1 immediately; rsp_valid=0, busy=0, FIFO empty. After release, cmd_ready=1 and a new command completes correctly.
